// File: rtl/ca_reg_read_seq_hd_if.sv
// Downstream group bus of the CA register read sequencer: one group of q/d digits per transfer.
interface ca_reg_read_seq_hd_if #(
    parameter int Num_bits       = 4,
    parameter int RAM_ADDR_WIDTH = 7
);
    // A transfer happens on a rising clk edge where out_valid and out_ready are both high;
    // once out_valid is high, it and every payload field hold steady until that transfer.
    logic                      out_valid;
    logic                      out_ready;
    logic [Num_bits-1:0]       out_q_plus;
    logic [Num_bits-1:0]       out_q_minus;
    logic [Num_bits-1:0]       out_d_plus;
    logic [Num_bits-1:0]       out_d_minus;
    logic [RAM_ADDR_WIDTH-1:0] out_group;

    modport master (
        output out_valid, out_q_plus, out_q_minus, out_d_plus, out_d_minus, out_group,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_q_plus, out_q_minus, out_d_plus, out_d_minus, out_group,
        output out_ready
    );
endinterface

// File: rtl/ca_reg_read_seq_hd.sv
// Read-side sequencer for the CA (q/d digit) register: issues bank reads, buffers groups in a 2-entry FIFO.
// Define CA_RD_AVAIL_CHECK_EN to gate each group read on the write-side master_cnt.
module ca_reg_read_seq_hd #(
    parameter int Num_bits       = 4,
    parameter int RAM_ADDR_WIDTH = 7
) (
    input  logic                      clk,
    input  logic                      async_clear,
    input  logic                      enable_all,
    input  logic                      start,
    input  logic [RAM_ADDR_WIDTH:0]   n_groups,
    input  logic [RAM_ADDR_WIDTH+1:0] master_cnt,
    output logic [RAM_ADDR_WIDTH-1:0] rd_addr,
    input  logic [Num_bits-1:0]       q_plus,
    input  logic [Num_bits-1:0]       q_minus,
    input  logic [Num_bits-1:0]       d_plus,
    input  logic [Num_bits-1:0]       d_minus,
    ca_reg_read_seq_hd_if.master      bus,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                fsm_state
);
    localparam int AW = RAM_ADDR_WIDTH;
    localparam logic [AW:0]   N_MAX   = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   N_ONE   = 1;
    localparam logic [AW-1:0] GRP_ONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [AW-1:0]       grp;
        logic [Num_bits-1:0] qp;
        logic [Num_bits-1:0] qm;
        logic [Num_bits-1:0] dp;
        logic [Num_bits-1:0] dm;
    } entry_t;

    state_t        state, state_nx;
    logic          done_nx, n_load;
    logic [AW:0]   n_lat, n_sat;
    logic [AW-1:0] grp, inflight_grp;
    logic          inflight;
    entry_t        fifo_mem [2];
    entry_t        head;
    logic          wr_ptr, rd_ptr;
    logic [1:0]    count, occ_after;
    logic          push, pop, avail, credit_ok, issue, last_issue;

`ifdef CA_RD_AVAIL_CHECK_EN
    localparam logic [AW+2:0] AVAIL_OFS = 5;
    logic [AW+2:0] need_cnt;

    // Group g needs d digits up to 4g+3 and the lagging q digits, hence master_cnt >= 4g+5.
    assign need_cnt = {1'b0, grp, 2'b00} + AVAIL_OFS;
    assign avail    = {1'b0, master_cnt} >= need_cnt;
`else
    logic unused_master_cnt;

    assign unused_master_cnt = ^master_cnt;
    assign avail             = 1'b1;
`endif

    assign bus.out_valid = (count != 2'd0);
    assign pop           = bus.out_valid & bus.out_ready;
    assign push          = inflight;
    assign n_sat         = (n_groups > N_MAX) ? N_MAX : n_groups;

    // Credit counts this cycle's pop so a steady stream can issue every cycle without overflow.
    assign occ_after  = count - {1'b0, pop};
    assign credit_ok  = ({1'b0, occ_after} + {2'b00, inflight}) < 3'd2;
    assign issue      = (state == ST_RUN) & enable_all & avail & credit_ok;
    assign last_issue = issue & ({1'b0, grp} == (n_lat - N_ONE));

    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        n_load   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && enable_all) begin
                    n_load   = 1'b1;
                    state_nx = (n_groups == '0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_issue) state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (enable_all && !inflight && (count == {1'b0, pop})) begin
                    state_nx = ST_IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (async_clear) begin
            state        <= ST_IDLE;
            done         <= 1'b0;
            n_lat        <= '0;
            grp          <= '0;
            inflight     <= 1'b0;
            inflight_grp <= '0;
        end else begin
            state    <= state_nx;
            done     <= done_nx;
            inflight <= issue;
            if (n_load) begin
                n_lat <= n_sat;
                grp   <= '0;
            end else if (issue) begin
                grp <= grp + GRP_ONE;
            end
            if (issue) inflight_grp <= grp;
        end
    end

    // Bank data arrives the cycle after issue and is captured regardless of enable_all.
    always_ff @(posedge clk) begin
        if (async_clear) begin
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= '{grp: inflight_grp, qp: q_plus, qm: q_minus,
                                      dp: d_plus, dm: d_minus};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head            = fifo_mem[rd_ptr];
    assign bus.out_q_plus  = bus.out_valid ? head.qp  : '0;
    assign bus.out_q_minus = bus.out_valid ? head.qm  : '0;
    assign bus.out_d_plus  = bus.out_valid ? head.dp  : '0;
    assign bus.out_d_minus = bus.out_valid ? head.dm  : '0;
    assign bus.out_group   = bus.out_valid ? head.grp : '0;

    assign rd_addr   = grp;
    assign busy      = (state != ST_IDLE);
    assign fsm_state = state;
endmodule

// File: tb/tb_ca_reg_read_seq_hd.sv
// Directed + randomized bench for ca_reg_read_seq_hd with a bank model, group scoreboard and timing checks.
module tb_ca_reg_read_seq_hd;
    localparam int NB = 4;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          async_clear, enable_all, start;
    logic [AW:0]   n_groups;
    logic [AW+1:0] master_cnt;
    logic [AW-1:0] rd_addr;
    logic [NB-1:0] q_plus, q_minus, d_plus, d_minus;
    logic          busy, done;
    logic [1:0]    fsm_state;

    ca_reg_read_seq_hd_if #(.Num_bits(NB), .RAM_ADDR_WIDTH(AW)) bus ();

    ca_reg_read_seq_hd #(.Num_bits(NB), .RAM_ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .async_clear(async_clear),
        .enable_all (enable_all),
        .start      (start),
        .n_groups   (n_groups),
        .master_cnt (master_cnt),
        .rd_addr    (rd_addr),
        .q_plus     (q_plus),
        .q_minus    (q_minus),
        .d_plus     (d_plus),
        .d_minus    (d_minus),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [NB-1:0] mem_qp [128];
    logic [NB-1:0] mem_qm [128];
    logic [NB-1:0] mem_dp [128];
    logic [NB-1:0] mem_dm [128];
    logic [AW-1:0] exp_q [$];
    int            acc_mc [$];

    logic rand_ready = 1'b0;
    logic rand_en    = 1'b0;
    logic auto_mc    = 1'b0;
    logic prev_done  = 1'b0;
    logic last_acc_en = 1'b0;
    int   accepts = 0;
    int   last_acc_cyc = -100;
    int   done_cnt = 0;
    int   done_cyc = -1;
    int   first_valid_cyc = -1;
    int   valid_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 128; i++) begin
            mem_qp[i] = NB'($urandom);
            mem_qm[i] = NB'($urandom);
            mem_dp[i] = NB'($urandom);
            mem_dm[i] = NB'($urandom);
        end
    endtask

    // Advance one clock; the bench plays the 1-cycle-latency banks and scores every transfer.
    task automatic step();
        logic [AW-1:0]   a, sg, g;
        logic [4*NB-1:0] sd;
        logic            hs, stall;
        if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
        if (rand_en)    enable_all    = ($urandom_range(0, 4) != 0);
        a     = rd_addr;
        hs    = bus.out_valid && bus.out_ready && !async_clear;
        stall = bus.out_valid && !bus.out_ready && !async_clear;
        sg    = bus.out_group;
        sd    = {bus.out_q_plus, bus.out_q_minus, bus.out_d_plus, bus.out_d_minus};
        if (bus.out_valid) begin
            valid_cnt++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (hs) begin
            chk("extra_output", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                g = exp_q.pop_front();
                chk("group", sg, g);
                chk("data", sd, {mem_qp[g], mem_qm[g], mem_dp[g], mem_dm[g]});
            end
            accepts++;
            last_acc_cyc = cyc;
            last_acc_en  = enable_all;
            acc_mc.push_back(int'(master_cnt));
        end
        @(posedge clk);
        #1;
        cyc++;
        q_plus  = mem_qp[a];
        q_minus = mem_qm[a];
        d_plus  = mem_dp[a];
        d_minus = mem_dm[a];
        if (auto_mc) master_cnt = master_cnt + 1'b1;
        if (stall && !async_clear) begin
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_group", bus.out_group, sg);
            chk("hold_data", {bus.out_q_plus, bus.out_q_minus, bus.out_d_plus, bus.out_d_minus}, sd);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_pulse", prev_done, 0);
            chk("done_busy", busy, 0);
            chk("done_empty", exp_q.size(), 0);
            if (accepts > 0 && last_acc_en) chk("done_latency", cyc, last_acc_cyc + 1);
        end
        prev_done = done;
    endtask

    task automatic do_start(input int n);
        int ne;
        ne = (n > 128) ? 128 : n;
        for (int g = 0; g < ne; g++) exp_q.push_back(g[AW-1:0]);
        accepts         = 0;
        first_valid_cyc = -1;
        valid_cnt       = 0;
        acc_mc.delete();
        enable_all = 1'b1;
        n_groups   = n[AW:0];
        start      = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        int d0;
        k  = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && k < budget) begin
            step();
            k++;
        end
        chk("done_timeout", done_cnt != d0, 1);
    endtask

    function automatic int exp_accept_mc(input int g);
`ifdef CA_RD_AVAIL_CHECK_EN
        return 4 * g + 7;
`else
        return g + 3;
`endif
    endfunction

    initial begin
        int t, n;
        logic [AW-1:0] r0;
        async_clear   = 1'b1;
        enable_all    = 1'b1;
        start         = 1'b0;
        n_groups      = '0;
        master_cnt    = '0;
        bus.out_ready = 1'b0;
        q_plus = '0; q_minus = '0; d_plus = '0; d_minus = '0;
        fill_mem();
        step();
        step();
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_group", bus.out_group, 0);
        chk("rst_data", {bus.out_q_plus, bus.out_q_minus, bus.out_d_plus, bus.out_d_minus}, 0);
        async_clear = 1'b0;
        step();

        // Four preloaded groups, downstream always ready.
        master_cnt    = 9'd31;
        bus.out_ready = 1'b1;
        t = cyc;
        do_start(4);
        chk("busy_after_start", busy, 1);
        wait_done(50);
        chk("burst_first_valid", first_valid_cyc, t + 3);
        chk("burst_last_accept", last_acc_cyc, t + 6);
        chk("burst_accepts", accepts, 4);
        chk("burst_done_cyc", done_cyc, t + 7);

        // Reader trailing the writer's digit counter.
        fill_mem();
        master_cnt = '0;
        auto_mc    = 1'b1;
        do_start(2);
        wait_done(60);
        auto_mc = 1'b0;
        chk("avail_accepts", acc_mc.size(), 2);
        if (acc_mc.size() >= 2) begin
            chk("avail_g0_mc", acc_mc[0], exp_accept_mc(0));
            chk("avail_g1_mc", acc_mc[1], exp_accept_mc(1));
        end

        // Downstream stall for five cycles mid-run.
        fill_mem();
        master_cnt    = 9'd200;
        bus.out_ready = 1'b1;
        do_start(8);
        for (int i = 0; i < 3; i++) step();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        r0 = rd_addr;
        step();
        step();
        chk("stall_addr_held", rd_addr, r0);
        chk("stall_entries", int'(rd_addr) - accepts, 2);
        bus.out_ready = 1'b1;
        wait_done(60);
        chk("stall_accepts", accepts, 8);

        // Clear with one read in flight and an entry buffered.
        fill_mem();
        bus.out_ready = 1'b0;
        do_start(8);
        step();
        step();
        async_clear = 1'b1;
        step();
        chk("mid_rst_rd_addr", rd_addr, 0);
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_group", bus.out_group, 0);
        chk("mid_rst_data", {bus.out_q_plus, bus.out_q_minus, bus.out_d_plus, bus.out_d_minus}, 0);
        async_clear = 1'b0;
        exp_q.delete();
        step();
        fill_mem();
        bus.out_ready = 1'b1;
        do_start(3);
        wait_done(40);
        chk("post_rst_accepts", accepts, 3);

        // Zero-length request, then start pulses while busy.
        t = cyc;
        do_start(0);
        chk("zero_busy", busy, 1);
        step();
        chk("zero_done", done, 1);
        chk("zero_done_cyc", done_cyc, t + 2);
        step();
        chk("zero_no_valid", valid_cnt, 0);
        fill_mem();
        do_start(5);
        step();
        n_groups = 8'd2;
        start    = 1'b1;
        step();
        start = 1'b0;
        step();
        n_groups = 8'd1;
        start    = 1'b1;
        step();
        start = 1'b0;
        wait_done(40);
        chk("ignored_start_accepts", accepts, 5);
        step();
        step();
        chk("ignored_start_idle", busy, 0);

        // Global enable dropped for three cycles in RUN.
        fill_mem();
        do_start(6);
        step();
        enable_all = 1'b0;
        r0 = rd_addr;
        step();
        chk("en_hold_1", rd_addr, r0);
        step();
        chk("en_hold_2", rd_addr, r0);
        step();
        chk("en_hold_3", rd_addr, r0);
        enable_all = 1'b1;
        wait_done(40);
        chk("en_accepts", accepts, 6);

`ifndef CA_RD_AVAIL_CHECK_EN
        // Oversized request saturates at the full bank depth.
        fill_mem();
        bus.out_ready = 1'b1;
        do_start(200);
        wait_done(400);
        chk("sat_accepts", accepts, 128);
`endif

        // Randomized runs with random backpressure and enable.
        master_cnt = 9'd200;
        for (int r = 0; r < 4; r++) begin
            fill_mem();
            rand_ready = 1'b1;
            n = int'($urandom_range(1, 20));
            do_start(n);
            rand_en = 1'b1;
            wait_done(400);
            rand_en    = 1'b0;
            enable_all = 1'b1;
            chk("rand_accepts", accepts, n);
        end
        rand_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
